// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier built on a 4x4 core.
// The step shift table places each nibble partial product at its weight.
package mul_seq_pkg;

    localparam int NIB_W  = 4;
    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SHIFT_0 = 4'd0;
    localparam logic [3:0] SHIFT_1 = 4'd4;
    localparam logic [3:0] SHIFT_2 = 4'd4;
    localparam logic [3:0] SHIFT_3 = 4'd8;

    function automatic logic [3:0] step_shift(input logic [1:0] idx);
        case (idx)
            2'd0:    return SHIFT_0;
            2'd1:    return SHIFT_1;
            2'd2:    return SHIFT_2;
            default: return SHIFT_3;
        endcase
    endfunction

endpackage

// File: rtl/mul4x4_array.sv
// Combinational 4x4 unsigned array multiplier: shifted-row partial sums, no storage.
module mul4x4_array
    import mul_seq_pkg::*;
(
    input  logic [NIB_W-1:0]   a,
    input  logic [NIB_W-1:0]   b,
    output logic [2*NIB_W-1:0] p
);

    always_comb begin
        p = '0;
        for (int i = 0; i < NIB_W; i++) begin
            if (b[i]) begin
                p = p + ((2*NIB_W)'(a) << i);
            end
        end
    end

endmodule

// File: rtl/mul8_seq_ctrl.sv
// Sequencer that runs the four nibble products of an 8x8 multiply through one
// 4x4 core on consecutive cycles and accumulates them into a 16-bit product.
module mul8_seq_ctrl
    import mul_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] p,
    output logic              busy
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and the holder of valid keeps its data stable.
    state_t              state;
    state_t              state_next;
    logic                accept;
    logic [1:0]          idx_q;
    logic [OP_W-1:0]     a_q;
    logic [OP_W-1:0]     b_q;
    logic [PROD_W-1:0]   acc_q;
    logic [PROD_W-1:0]   p_q;
    logic [PROD_W-1:0]   acc_next;
    logic [NIB_W-1:0]    nib_a;
    logic [NIB_W-1:0]    nib_b;
    logic [2*NIB_W-1:0]  pp;
    logic                busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = MUL;
            MUL:  if (idx_q == 2'd3) state_next = DONE;
            DONE: if (out_ready) state_next = in_valid ? MUL : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
        out_valid = (state == DONE);
        accept    = in_valid && in_ready;
    end

    // idx[0] picks the high nibble of a, idx[1] the high nibble of b.
    assign nib_a    = idx_q[0] ? a_q[7:4] : a_q[3:0];
    assign nib_b    = idx_q[1] ? b_q[7:4] : b_q[3:0];
    assign acc_next = acc_q + (PROD_W'(pp) << step_shift(idx_q));

    mul4x4_array u_core (
        .a (nib_a),
        .b (nib_b),
        .p (pp)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            idx_q  <= '0;
            p_q    <= '0;
            busy_q <= 1'b0;
        end else begin
            if (accept) begin
                a_q   <= a;
                b_q   <= b;
                acc_q <= '0;
                idx_q <= '0;
            end else if (state == MUL) begin
                acc_q <= acc_next;
                idx_q <= idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    p_q <= acc_next;
                end
            end
            busy_q <= (state_next == MUL);
        end
    end

    assign p    = p_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Self-checking bench for mul8_seq_ctrl: scoreboard of products, latency and
// busy models, backpressure, back-to-back and mid-operation reset scenarios.
module tb_mul8_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;
    logic        busy;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          busy_left = 0;
    int          last_acc = 0;
    int          mon_ac;
    logic        acc_pend = 1'b0;
    logic        prev_ov  = 1'b0;
    logic [15:0] exp_q[$];
    int          acc_cyc_q[$];

    mul8_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    // clock and cycle count
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n)          busy_left <= 0;
        else if (acc_pend)   busy_left <= 4;
        else if (busy_left > 0) busy_left <= busy_left - 1;
    end

    task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, act, exp);
        end
    endtask

    // monitor and scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            check_val("busy", 16'(busy), 16'(busy_left > 0));
            if (out_valid && !prev_ov) begin
                if (acc_cyc_q.size() == 0) begin
                    check_val("lat_unexp", 16'(acc_cyc_q.size()), 16'd1);
                end else begin
                    mon_ac = acc_cyc_q.pop_front();
                    check_val("latency", 16'(cyc - mon_ac), 16'd4);
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check_val("sb_empty", 16'(exp_q.size()), 16'd1);
                else                   check_val("product", p, exp_q.pop_front());
            end
            acc_pend = in_valid && in_ready;
            prev_ov  = out_valid;
        end else begin
            acc_pend = 1'b0;
            prev_ov  = 1'b0;
        end
    end

    // driver tasks: all enter and leave one time unit after a rising edge
    task automatic send(input logic [7:0] na, input logic [7:0] nb);
        int n = 0;
        a        = na;
        b        = nb;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check_val("accept_timeout", 16'(in_ready), 16'd1);
        end else begin
            exp_q.push_back(16'(na) * 16'(nb));
            acc_cyc_q.push_back(cyc + 1);
            last_acc = cyc + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        in_valid = 1'b0;
        a        = 8'($urandom_range(0, 255));
        b        = 8'($urandom_range(0, 255));
    endtask

    task automatic scramble(input int n);
        for (int i = 0; i < n; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check_val("drain_timeout", 16'(exp_q.size()), 16'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check_val({tag, "_in_ready"}, 16'(in_ready), 16'd1);
        check_val({tag, "_out_valid"}, 16'(out_valid), 16'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 8'd0;
        b         = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_p", p, 16'h0000);
        check_val("rst_out_valid", 16'(out_valid), 16'd0);
        check_val("rst_busy", 16'(busy), 16'd0);
        check_val("rst_in_ready", 16'(in_ready), 16'd1);
        @(posedge clk);
        #1;

        // basic operation, operands scrambled while multiplying
        send(8'd200, 8'd150);
        go_idle();
        @(negedge clk);
        check_val("mul_in_ready", 16'(in_ready), 16'd0);
        @(posedge clk);
        #1;
        scramble(2);
        drain();
        check_idle("t1");

        send(8'hFF, 8'hFF); go_idle(); scramble(3); drain();
        send(8'h00, 8'hA5); go_idle(); scramble(3); drain();
        send(8'h12, 8'h34); go_idle(); scramble(3); drain();
        for (int i = 0; i < 6; i++) begin
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            go_idle();
            drain();
        end

        // backpressure
        out_ready = 1'b0;
        send(8'h0F, 8'h10);
        go_idle();
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("bp_reach_done", 16'(out_valid), 16'd1);
        for (int i = 0; i < 10; i++) begin
            check_val("bp_p", p, 16'h00F0);
            check_val("bp_out_valid", 16'(out_valid), 16'd1);
            check_val("bp_in_ready", 16'(in_ready), 16'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val("bp_retired", 16'(out_valid), 16'd0);
        check_val("bp_idle_ready", 16'(in_ready), 16'd1);
        @(posedge clk);
        #1;
        check_val("bp_sb_empty", 16'(exp_q.size()), 16'd0);

        // back-to-back
        send(8'd3, 8'd5);
        t0 = last_acc;
        send(8'h80, 8'd2);
        check_val("b2b_spacing1", 16'(last_acc - t0), 16'd5);
        t0 = last_acc;
        send(8'hF0, 8'hF0);
        check_val("b2b_spacing2", 16'(last_acc - t0), 16'd5);
        go_idle();
        drain();
        check_idle("b2b");

        // reset during step 2 discards the operation
        send(8'hAB, 8'hCD);
        go_idle();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        acc_cyc_q.delete();
        @(negedge clk);
        check_val("mrst_out_valid", 16'(out_valid), 16'd0);
        check_val("mrst_p", p, 16'h0000);
        check_val("mrst_in_ready", 16'(in_ready), 16'd1);
        check_val("mrst_busy", 16'(busy), 16'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_val("mrst_no_out", 16'(out_valid), 16'd0);
        end
        @(posedge clk);
        #1;
        send(8'h02, 8'h03);
        go_idle();
        drain();
        check_idle("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
